// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared seven-segment constants for the display blocks
package bcd_display_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODES_OFF = 4'b1111;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low {g..a} segments, dash for invalid codes
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    // blank wins over the digit value; codes 10..15 render as a dash
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) seg_o = SEG_BLANK;
        else begin
            case (digit_i)
                4'd0: seg_o = SEG_0;
                4'd1: seg_o = SEG_1;
                4'd2: seg_o = SEG_2;
                4'd3: seg_o = SEG_3;
                4'd4: seg_o = SEG_4;
                4'd5: seg_o = SEG_5;
                4'd6: seg_o = SEG_6;
                4'd7: seg_o = SEG_7;
                4'd8: seg_o = SEG_8;
                4'd9: seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: 4-digit multiplexed seven-segment scanner with guard band and leading-zero blanking
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] DigitsIn,
    input  logic [3:0]  DotIn,
    input  logic        BlankLeading,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  An,
    output logic [1:0]  ScanIdx
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    dsnap_q, dsnap_d;
    logic          wrap;
    logic [3:0]    blank;
    logic [3:0]    digit;
    logic [6:0]    seg_d, seg_q;
    logic [3:0]    an_d, an_q;
    logic          dp_q;
    logic [1:0]    scan_q;

    // slot counter, digit index and once-per-scan snapshot (only on the 3->0 wrap)
    always_comb begin
        wrap    = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        snap_d  = (wrap && idx_q == 2'd3) ? DigitsIn : snap_q;
        dsnap_d = (wrap && idx_q == 2'd3) ? DotIn : dsnap_q;
        an_d    = (cnt_q < CW'(GUARD_CYCLES)) ? ANODES_OFF : ~(4'b0001 << idx_q);
    end

    // a digit blanks only if it is zero and everything to its left is blanked
    assign blank[3] = BlankLeading && snap_q[15:12] == 4'd0;
    assign blank[2] = blank[3] && snap_q[11:8] == 4'd0;
    assign blank[1] = blank[2] && snap_q[7:4] == 4'd0;
    assign blank[0] = 1'b0;
    assign digit    = snap_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_dec (
        .digit_i (digit),
        .blank_i (blank[idx_q]),
        .seg_o   (seg_d)
    );

    // scan state and registered display outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            dsnap_q <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= ANODES_OFF;
            dp_q    <= 1'b1;
            scan_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            dsnap_q <= dsnap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= ~dsnap_q[idx_q];
            scan_q  <= idx_q;
        end
    end

    assign Seg     = seg_q;
    assign Dp      = dp_q;
    assign An      = an_q;
    assign ScanIdx = scan_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed checks of scan timing, decode, blanking, snapshot and reset
module tb_bcd_display_scan;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] DigitsIn = 16'h1234;
    logic [3:0]  DotIn = 4'b0000;
    logic        BlankLeading = 1'b0;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  An;
    logic [1:0]  ScanIdx;

    int errors = 0;
    int checks = 0;
    int ncyc = 0;

    bcd_display_scan #(.REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .DigitsIn     (DigitsIn),
        .DotIn        (DotIn),
        .BlankLeading (BlankLeading),
        .Seg          (Seg),
        .Dp           (Dp),
        .An           (An),
        .ScanIdx      (ScanIdx)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 1 ns after rising edge k counted from reset release
    task automatic at(input int k);
        while (ncyc < k) begin
            @(posedge Clk);
            ncyc++;
        end
        #1;
    endtask

    // outputs after edge k reflect state cnt=(k-1)%8, idx=((k-1)/8)%4
    task automatic slot_chk(input string tag, input int base, input int i,
                            input logic [6:0] seg, input logic dp);
        for (int c = 0; c < 8; c++) begin
            at(base + i*8 + c + 1);
            chk({tag, "_scan"}, {14'd0, ScanIdx}, 16'(i));
            chk({tag, "_an"}, {12'd0, An}, (c < 2) ? 16'h000F : {12'd0, ~(4'b0001 << i)});
            if (c >= 2) begin
                chk({tag, "_seg"}, {9'd0, Seg}, {9'd0, seg});
                chk({tag, "_dp"}, {15'd0, Dp}, {15'd0, dp});
            end
        end
    endtask

    initial begin
        logic [6:0] s1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        repeat (5) @(posedge Clk);
        #1;
        chk("rst_an", {12'd0, An}, 16'h000F);
        chk("rst_seg", {9'd0, Seg}, 16'h007F);
        chk("rst_dp", {15'd0, Dp}, 16'h0001);
        chk("rst_scan", {14'd0, ScanIdx}, 16'h0000);
        Reset = 1'b1;
        ncyc = 0;
        at(1);
        chk("first_guard_an", {12'd0, An}, 16'h000F);
        at(3);
        chk("first_scan_an", {12'd0, An}, 16'h000E);
        chk("first_scan_seg", {9'd0, Seg}, 16'h0040);
        for (int i = 0; i < 4; i++) slot_chk("s1234", 32, i, s1234[i], 1'b1);
        at(65);
        chk("period_scan", {14'd0, ScanIdx}, 16'h0000);
        at(75);
        DigitsIn = 16'h5678;
        at(83);
        chk("tear_slot2", {9'd0, Seg}, 16'h0024);
        at(91);
        chk("tear_slot3", {9'd0, Seg}, 16'h0079);
        at(99);
        chk("new_d0", {9'd0, Seg}, 16'h0000);
        at(107);
        chk("new_d1", {9'd0, Seg}, 16'h0078);
        at(115);
        chk("new_d2", {9'd0, Seg}, 16'h0002);
        at(123);
        chk("new_d3", {9'd0, Seg}, 16'h0012);
        DigitsIn = 16'h0050;
        BlankLeading = 1'b1;
        at(131);
        chk("blank_d0", {9'd0, Seg}, 16'h0040);
        at(139);
        chk("blank_d1", {9'd0, Seg}, 16'h0012);
        at(147);
        chk("blank_d2", {9'd0, Seg}, 16'h007F);
        at(155);
        chk("blank_d3", {9'd0, Seg}, 16'h007F);
        chk("blank_d3_an", {12'd0, An}, 16'h0007);
        at(170);
        chk("blank_on_d1", {9'd0, Seg}, 16'h0012);
        at(178);
        BlankLeading = 1'b0;
        at(179);
        chk("noblank_d2", {9'd0, Seg}, 16'h0040);
        at(187);
        chk("noblank_d3", {9'd0, Seg}, 16'h0040);
        DigitsIn = 16'hA0F9;
        DotIn = 4'b0100;
        slot_chk("inv_d0", 192, 0, 7'h10, 1'b1);
        slot_chk("inv_d1", 192, 1, 7'h3F, 1'b1);
        slot_chk("inv_d2", 192, 2, 7'h40, 1'b0);
        slot_chk("inv_d3", 192, 3, 7'h3F, 1'b1);
        at(244);
        chk("pre_rst_an", {12'd0, An}, 16'h000B);
        chk("pre_rst_scan", {14'd0, ScanIdx}, 16'h0002);
        Reset = 1'b0;
        #1;
        chk("mid_rst_an", {12'd0, An}, 16'h000F);
        chk("mid_rst_seg", {9'd0, Seg}, 16'h007F);
        chk("mid_rst_dp", {15'd0, Dp}, 16'h0001);
        chk("mid_rst_scan", {14'd0, ScanIdx}, 16'h0000);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        ncyc = 0;
        at(1);
        chk("rel_scan", {14'd0, ScanIdx}, 16'h0000);
        chk("rel_an", {12'd0, An}, 16'h000F);
        at(3);
        chk("rel_an_on", {12'd0, An}, 16'h000E);
        chk("rel_seg", {9'd0, Seg}, 16'h0040);
        chk("rel_dp", {15'd0, Dp}, 16'h0001);
        at(9);
        chk("rel_scan1", {14'd0, ScanIdx}, 16'h0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
